// File: rtl/home_particle_broadcaster_pkg.sv
// Shared constants and FSM encoding for the home-cell particle broadcaster.
// Particle ids are 1-based; RAM address 0 holds the particle count.
package home_particle_broadcaster_pkg;

    localparam int OFFSET_WIDTH_DEF      = 29;
    localparam int PARTICLE_ID_WIDTH_DEF = 7;
    localparam int DRAIN_CYCLES_DEF      = 8;
    localparam int COUNT_ADDR            = 0;
    localparam int FIRST_ID              = 1;
    localparam int FLUSH_CYCLES          = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_NUM,
        S_WAIT_NUM,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_FINISH
    } state_t;

endpackage

// File: rtl/home_particle_broadcaster_bcast_read_pipe.sv
// Two-stage delay line that keeps {particle_id, valid, count-flag} aligned
// with the one-cycle-latency RAM word and registers the broadcast outputs.
module bcast_read_pipe
    import home_particle_broadcaster_pkg::*;
#(
    parameter int OFFSET_WIDTH      = OFFSET_WIDTH_DEF,
    parameter int PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_rd_en,
    input  logic                         i_rd_cnt,
    input  logic [PARTICLE_ID_WIDTH-1:0] i_rd_addr,
    input  logic [OFFSET_WIDTH-1:0]      i_rd_data_x,
    input  logic [OFFSET_WIDTH-1:0]      i_rd_data_y,
    input  logic [OFFSET_WIDTH-1:0]      i_rd_data_z,
    output logic [OFFSET_WIDTH-1:0]      o_pos_x,
    output logic [OFFSET_WIDTH-1:0]      o_pos_y,
    output logic [OFFSET_WIDTH-1:0]      o_pos_z,
    output logic [PARTICLE_ID_WIDTH-1:0] o_particle_id,
    output logic                         o_data_valid,
    output logic                         o_reading_num
);

    logic                         r_vld_p0, r_num_p0;
    logic [PARTICLE_ID_WIDTH-1:0] r_id_p0;
    logic                         r_vld_p1, r_num_p1;
    logic [PARTICLE_ID_WIDTH-1:0] r_id_p1;
    logic [OFFSET_WIDTH-1:0]      r_x_p1, r_y_p1, r_z_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_num_p0 <= 1'b0;
            r_id_p0  <= '0;
            r_vld_p1 <= 1'b0;
            r_num_p1 <= 1'b0;
            r_id_p1  <= '0;
            r_x_p1   <= '0;
            r_y_p1   <= '0;
            r_z_p1   <= '0;
        end else begin
            // Stage p0: request tag lines up with the RAM word arriving now
            r_vld_p0 <= i_rd_en & ~i_rd_cnt;
            r_num_p0 <= i_rd_en & i_rd_cnt;
            r_id_p0  <= i_rd_addr;
            // Stage p1: capture the word; outputs hold across bubbles
            r_vld_p1 <= r_vld_p0;
            r_num_p1 <= r_num_p0;
            if (r_vld_p0) begin
                r_id_p1 <= r_id_p0;
            end
            if (r_vld_p0 | r_num_p0) begin
                r_x_p1 <= i_rd_data_x;
                r_y_p1 <= i_rd_data_y;
                r_z_p1 <= i_rd_data_z;
            end
        end
    end

    assign o_pos_x       = r_x_p1;
    assign o_pos_y       = r_y_p1;
    assign o_pos_z       = r_z_p1;
    assign o_particle_id = r_id_p1;
    assign o_data_valid  = r_vld_p1;
    assign o_reading_num = r_num_p1;

endmodule

// File: rtl/home_particle_broadcaster.sv
// Home-cell particle broadcaster: reads the count word, then runs one pass per
// reference particle streaming ids ref_id..N, with a phase=1 drain between passes.
module home_particle_broadcaster
    import home_particle_broadcaster_pkg::*;
#(
    parameter int OFFSET_WIDTH      = OFFSET_WIDTH_DEF,
    parameter int PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEF,
    parameter int DRAIN_CYCLES      = DRAIN_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
    input  logic [OFFSET_WIDTH-1:0]      rd_data_x,
    input  logic [OFFSET_WIDTH-1:0]      rd_data_y,
    input  logic [OFFSET_WIDTH-1:0]      rd_data_z,
    output logic [OFFSET_WIDTH-1:0]      raw_home_pos_x,
    output logic [OFFSET_WIDTH-1:0]      raw_home_pos_y,
    output logic [OFFSET_WIDTH-1:0]      raw_home_pos_z,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         data_valid,
    output logic                         reading_particle_num,
    output logic                         phase,
    output logic                         prev_phase,
    output logic                         busy,
    output logic                         done
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

    state_t                       r_state;
    logic                         r_rd_en, r_rd_cnt;
    logic                         r_phase, r_prev_phase, r_busy, r_done;
    logic [PARTICLE_ID_WIDTH-1:0] r_rd_addr, r_ref_id, r_num;
    logic [CNT_W-1:0]             r_cnt;
    logic [PARTICLE_ID_WIDTH-1:0] w_rd_num;

    assign w_rd_num = rd_data_x[PARTICLE_ID_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rd_en      <= 1'b0;
            r_rd_cnt     <= 1'b0;
            r_rd_addr    <= '0;
            r_ref_id     <= '0;
            r_num        <= '0;
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_prev_phase <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_prev_phase <= r_phase;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_rd_cnt  <= 1'b1;
                        r_rd_addr <= PARTICLE_ID_WIDTH'(COUNT_ADDR);
                        r_state   <= S_RD_NUM;
                    end
                end
                S_RD_NUM: begin
                    r_rd_en  <= 1'b0;
                    r_rd_cnt <= 1'b0;
                    r_state  <= S_WAIT_NUM;
                end
                S_WAIT_NUM: begin
                    r_num <= w_rd_num;
                    if (w_rd_num == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_ref_id  <= PARTICLE_ID_WIDTH'(FIRST_ID);
                        r_phase   <= 1'b0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= PARTICLE_ID_WIDTH'(FIRST_ID);
                        r_state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // Exact compare against N so the all-ones count never wraps
                    if (r_rd_addr == r_num) begin
                        r_rd_en <= 1'b0;
                        r_cnt   <= CNT_W'(FLUSH_CYCLES - 1);
                        r_state <= S_FLUSH;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_phase <= 1'b1;
                        r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (r_ref_id == r_num) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            // New ref_id is visible on the same cycle phase falls
                            r_ref_id  <= r_ref_id + 1'b1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_ref_id + 1'b1;
                            r_state   <= S_STREAM;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    bcast_read_pipe #(
        .OFFSET_WIDTH      (OFFSET_WIDTH),
        .PARTICLE_ID_WIDTH (PARTICLE_ID_WIDTH)
    ) u_read_pipe (
        .clk           (clk),
        .rst           (rst),
        .i_rd_en       (r_rd_en),
        .i_rd_cnt      (r_rd_cnt),
        .i_rd_addr     (r_rd_addr),
        .i_rd_data_x   (rd_data_x),
        .i_rd_data_y   (rd_data_y),
        .i_rd_data_z   (rd_data_z),
        .o_pos_x       (raw_home_pos_x),
        .o_pos_y       (raw_home_pos_y),
        .o_pos_z       (raw_home_pos_z),
        .o_particle_id (particle_id),
        .o_data_valid  (data_valid),
        .o_reading_num (reading_particle_num)
    );

    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign ref_id     = r_ref_id;
    assign phase      = r_phase;
    assign prev_phase = r_prev_phase;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_home_particle_broadcaster.sv
// Bench for home_particle_broadcaster: RAM model plus a pass/stream reference
// model derived from the broadcast rules (N passes, pass r carries ids r..N).
module tb_home_particle_broadcaster;

    localparam int OW = 29;
    localparam int IW = 7;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rd_en;
    logic [IW-1:0] rd_addr;
    logic [OW-1:0] rd_data_x, rd_data_y, rd_data_z;
    logic [OW-1:0] raw_home_pos_x, raw_home_pos_y, raw_home_pos_z;
    logic [IW-1:0] particle_id, ref_id;
    logic          data_valid, reading_particle_num, phase, prev_phase, busy, done;

    home_particle_broadcaster dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .rd_en                (rd_en),
        .rd_addr              (rd_addr),
        .rd_data_x            (rd_data_x),
        .rd_data_y            (rd_data_y),
        .rd_data_z            (rd_data_z),
        .raw_home_pos_x       (raw_home_pos_x),
        .raw_home_pos_y       (raw_home_pos_y),
        .raw_home_pos_z       (raw_home_pos_z),
        .particle_id          (particle_id),
        .ref_id               (ref_id),
        .data_valid           (data_valid),
        .reading_particle_num (reading_particle_num),
        .phase                (phase),
        .prev_phase           (prev_phase),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] mem_x [128];
    logic [OW-1:0] mem_y [128];
    logic [OW-1:0] mem_z [128];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_x <= mem_x[rd_addr];
            rd_data_y <= mem_y[rd_addr];
            rd_data_z <= mem_z[rd_addr];
        end
    end

    int checks = 0;
    int passed = 0;

    // Observations from one broadcast
    logic [IW-1:0] o_ids[$];
    logic [OW-1:0] o_xs[$], o_ys[$], o_zs[$];
    int            o_runs[$];
    logic [IW-1:0] o_edge_ref[$];
    logic          o_edge_dv[$];
    int            o_cnt_pulses, o_done, o_done_cyc, o_dv_in_phase1, o_prev_bad;
    int            o_busy_gap, o_phase_hi;
    logic [OW-1:0] o_cnt_x;
    logic          o_busy_end;

    task automatic load_ram(input int n);
        mem_x[0] = OW'(n);
        mem_y[0] = OW'($urandom);
        mem_z[0] = OW'($urandom);
        for (int i = 1; i < 128; i++) begin
            mem_x[i] = OW'($urandom);
            mem_y[i] = OW'($urandom);
            mem_z[i] = OW'($urandom);
        end
    endtask

    function automatic int exp_done_cycle(input int n);
        return 3 + (n * (n + 1)) / 2 + n * (2 + D);
    endfunction

    // Reference stream: pass r (1..n) carries ids r..n in order
    function automatic int stream_errors(input int n);
        int errs = 0;
        int k = 0;
        for (int r = 1; r <= n; r++) begin
            for (int i = r; i <= n; i++) begin
                if (k >= o_ids.size()) errs++;
                else if (o_ids[k] !== IW'(i) || o_xs[k] !== mem_x[i] ||
                         o_ys[k] !== mem_y[i] || o_zs[k] !== mem_z[i]) errs++;
                k++;
            end
        end
        if (o_ids.size() != k) errs++;
        return errs;
    endfunction

    // Each drain of exactly D cycles; falling edge k carries the next reference
    function automatic int phase_errors(input int n);
        int errs = 0;
        if (o_runs.size() != n || o_edge_ref.size() != n) errs++;
        foreach (o_runs[k]) if (o_runs[k] != D) errs++;
        foreach (o_edge_ref[k]) begin
            if (o_edge_ref[k] !== IW'((k + 1 < n) ? k + 2 : n)) errs++;
            if (o_edge_dv[k] !== 1'b0) errs++;
        end
        return errs;
    endfunction

    task automatic observe(input int n, input int restart_at);
        int run = 0;
        logic last_phase = 1'b0;
        int budget = exp_done_cycle(n) + 40;
        o_ids.delete(); o_xs.delete(); o_ys.delete(); o_zs.delete();
        o_runs.delete(); o_edge_ref.delete(); o_edge_dv.delete();
        o_cnt_pulses = 0; o_done = 0; o_done_cyc = -1; o_dv_in_phase1 = 0;
        o_prev_bad = 0; o_busy_gap = 0; o_phase_hi = 0; o_cnt_x = '0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (reading_particle_num) begin
                o_cnt_pulses++;
                o_cnt_x = raw_home_pos_x;
            end
            if (data_valid) begin
                o_ids.push_back(particle_id);
                o_xs.push_back(raw_home_pos_x);
                o_ys.push_back(raw_home_pos_y);
                o_zs.push_back(raw_home_pos_z);
                if (phase) o_dv_in_phase1++;
            end
            if (phase) begin
                run++;
                o_phase_hi++;
            end
            if (prev_phase !== last_phase) o_prev_bad++;
            if (last_phase && !phase) begin
                o_runs.push_back(run);
                run = 0;
            end
            if (prev_phase && !phase) begin
                o_edge_ref.push_back(ref_id);
                o_edge_dv.push_back(data_valid);
            end
            last_phase = phase;
            if (done) begin
                o_done++;
                if (o_done_cyc < 0) o_done_cyc = cyc;
            end else if (o_done_cyc < 0 && !busy) begin
                o_busy_gap++;
            end
            if (o_done_cyc >= 0 && cyc >= o_done_cyc + 3) break;
        end
        o_busy_end = busy;
    endtask

    task automatic test_reset();
        logic [OW*3+IW*3+8-1:0] all_out;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        all_out = {rd_en, rd_addr, raw_home_pos_x, raw_home_pos_y, raw_home_pos_z, particle_id,
                   ref_id, data_valid, reading_particle_num, phase, prev_phase, busy, done};
        checks++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else passed++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, rd_en, phase, done} !== 4'b0) $display("FAIL idle_after_reset: got %b want 0000", {busy, rd_en, phase, done});
        else passed++;
    endtask

    task automatic test_stream_passes();
        int errs;
        load_ram(3);
        observe(3, -1);
        checks++;
        if (o_cnt_pulses !== 1 || o_cnt_x !== OW'(3)) $display("FAIL n3_count_word: pulses %0d x %0d want 1 / 3", o_cnt_pulses, o_cnt_x);
        else passed++;
        errs = stream_errors(3);
        checks++;
        if (errs !== 0) $display("FAIL n3_stream: %0d errors, got %0d words want 6", errs, o_ids.size());
        else passed++;
        checks++;
        if (o_done !== 1 || o_done_cyc !== exp_done_cycle(3)) $display("FAIL n3_done: pulses %0d at cycle %0d want 1 at %0d", o_done, o_done_cyc, exp_done_cycle(3));
        else passed++;
        checks++;
        if (o_busy_gap !== 0 || o_busy_end !== 1'b0) $display("FAIL n3_busy: gaps %0d end %b want 0 / 0", o_busy_gap, o_busy_end);
        else passed++;
    endtask

    task automatic test_drain_edges();
        int errs;
        load_ram(3);
        observe(3, -1);
        errs = phase_errors(3);
        checks++;
        if (errs !== 0) $display("FAIL n3_phase_edges: %0d errors, runs %0d edges %0d want 3", errs, o_runs.size(), o_edge_ref.size());
        else passed++;
        checks++;
        if (o_prev_bad !== 0 || o_dv_in_phase1 !== 0) $display("FAIL n3_prev_phase: prev_bad %0d dv_in_drain %0d want 0 / 0", o_prev_bad, o_dv_in_phase1);
        else passed++;
    endtask

    task automatic test_zero_count();
        load_ram(0);
        observe(0, -1);
        checks++;
        if (o_cnt_pulses !== 1 || o_cnt_x !== OW'(0)) $display("FAIL n0_count_word: pulses %0d x %0d want 1 / 0", o_cnt_pulses, o_cnt_x);
        else passed++;
        checks++;
        if (o_ids.size() !== 0 || o_phase_hi !== 0) $display("FAIL n0_quiet: words %0d phase_hi %0d want 0 / 0", o_ids.size(), o_phase_hi);
        else passed++;
        checks++;
        if (o_done !== 1 || o_done_cyc !== 3) $display("FAIL n0_done: pulses %0d at cycle %0d want 1 at 3", o_done, o_done_cyc);
        else passed++;
    endtask

    task automatic test_random_counts();
        int n, errs;
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(12, 1);
            load_ram(n);
            // Upper count-word bits above the id field must be ignored
            mem_x[0] = mem_x[0] | (OW'($urandom_range(3, 0)) << IW);
            observe(n, -1);
            errs = stream_errors(n) + phase_errors(n);
            checks++;
            if (errs !== 0) $display("FAIL rand_n%0d_stream: %0d errors, words %0d", n, errs, o_ids.size());
            else passed++;
            checks++;
            if (o_done !== 1 || o_done_cyc !== exp_done_cycle(n)) $display("FAIL rand_n%0d_done: pulses %0d at %0d want 1 at %0d", n, o_done, o_done_cyc, exp_done_cycle(n));
            else passed++;
        end
    endtask

    task automatic test_max_count();
        int errs;
        load_ram(127);
        observe(127, -1);
        errs = stream_errors(127);
        checks++;
        if (errs !== 0 || o_ids.size() !== 8128) $display("FAIL n127_stream: %0d errors, got %0d words want 8128", errs, o_ids.size());
        else passed++;
        checks++;
        if (o_ids.size() < 2 || o_ids[o_ids.size()-1] !== 7'd127 || o_ids[o_ids.size()-2] !== 7'd127) $display("FAIL n127_last_pass: last ids not 127,127 (words %0d)", o_ids.size());
        else passed++;
        checks++;
        if (o_done !== 1 || o_done_cyc !== exp_done_cycle(127) || phase_errors(127) !== 0) $display("FAIL n127_done: pulses %0d at %0d want 1 at %0d", o_done, o_done_cyc, exp_done_cycle(127));
        else passed++;
    endtask

    task automatic test_start_while_busy();
        int errs;
        load_ram(4);
        observe(4, 6);
        errs = stream_errors(4) + phase_errors(4);
        checks++;
        if (errs !== 0) $display("FAIL busy_start_stream: %0d errors, words %0d want 10", errs, o_ids.size());
        else passed++;
        checks++;
        if (o_cnt_pulses !== 1 || o_done !== 1 || o_done_cyc !== exp_done_cycle(4)) $display("FAIL busy_start_timing: cnt %0d done %0d at %0d want 1/1 at %0d", o_cnt_pulses, o_done, o_done_cyc, exp_done_cycle(4));
        else passed++;
    endtask

    task automatic test_reset_mid_stream();
        logic [OW*3+IW*3+8-1:0] all_out;
        bit found = 0;
        int errs;
        load_ram(5);
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (ref_id == 7'd2 && data_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) $display("FAIL mid_reset_reach_pass2: got no pass-2 word want one within 300 cycles");
        else passed++;
        #2 rst = 1'b1;
        #1;
        all_out = {rd_en, rd_addr, raw_home_pos_x, raw_home_pos_y, raw_home_pos_z, particle_id,
                   ref_id, data_valid, reading_particle_num, phase, prev_phase, busy, done};
        checks++;
        if (all_out !== '0) $display("FAIL mid_reset_async: got %h want 0", all_out);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        observe(5, -1);
        errs = stream_errors(5) + phase_errors(5);
        checks++;
        if (o_cnt_pulses !== 1 || o_cnt_x !== OW'(5) || errs !== 0) $display("FAIL mid_reset_replay: cnt %0d x %0d errs %0d want 1 / 5 / 0", o_cnt_pulses, o_cnt_x, errs);
        else passed++;
        checks++;
        if (o_done !== 1 || o_done_cyc !== exp_done_cycle(5)) $display("FAIL mid_reset_done: pulses %0d at %0d want 1 at %0d", o_done, o_done_cyc, exp_done_cycle(5));
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_stream_passes();
        test_drain_edges();
        test_zero_count();
        test_random_counts();
        test_start_while_busy();
        test_reset_mid_stream();
        test_max_count();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/home_particle_broadcaster.md
Name: home_particle_broadcaster

Overview:
Transmit side of the home-cell particle broadcast that the per-pipeline reference extractors consume. On start, it reads the home-cell position RAM and emits one particle-count word. It then runs one pass per reference particle, streaming particle ids ref_id..N each pass. It drives phase/prev_phase so receivers latch the next reference on the phase 1->0 edge. It sits between the home-cell position memory and every force pipeline in the cell.

Parameters:
OFFSET_WIDTH, 29, width of a position offset word per axis
PARTICLE_ID_WIDTH, 7, particle id / count width; ids are 1-based, RAM address = id, address 0 holds the count
DRAIN_CYCLES, 8, cycles phase stays 1 between passes (pipeline drain), minimum 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse, begins a broadcast; ignored while busy
rd_en  out  1  RAM read enable
rd_addr  out  PARTICLE_ID_WIDTH  RAM read address
rd_data_x  in  OFFSET_WIDTH  RAM x word, valid 1 cycle after rd_en
rd_data_y  in  OFFSET_WIDTH  RAM y word
rd_data_z  in  OFFSET_WIDTH  RAM z word
raw_home_pos_x  out  OFFSET_WIDTH  broadcast x offset (count word during reading_particle_num)
raw_home_pos_y  out  OFFSET_WIDTH  broadcast y offset
raw_home_pos_z  out  OFFSET_WIDTH  broadcast z offset
particle_id  out  PARTICLE_ID_WIDTH  id of the word on raw_home_pos_*
ref_id  out  PARTICLE_ID_WIDTH  current reference particle id
data_valid  out  1  raw_home_pos_*/particle_id carry a streamed particle
reading_particle_num  out  1  raw_home_pos_x carries the count word
phase  out  1  0 = streaming, 1 = draining
prev_phase  out  1  phase delayed one cycle
busy  out  1  broadcast in progress
done  out  1  one-cycle pulse at end of broadcast

Behaviour:
- Reset (async, any state): all outputs 0, FSM to IDLE, internal counters 0.
- Read path: rd_en/rd_addr issued at cycle t; RAM data at t+1; registered onto raw_home_pos_* at t+2. particle_id and data_valid are delayed 2 stages to stay aligned. Outputs hold their last value when data_valid=0.
- FSM states: IDLE, RD_NUM, WAIT_NUM, STREAM, FLUSH, DRAIN, FINISH.
- IDLE: busy=0. On start: busy=1, issue rd_addr=0, go to RD_NUM.
- RD_NUM -> WAIT_NUM: at t+2, reading_particle_num=1 for exactly one cycle, data_valid=0. N is taken as rd_data_x[PARTICLE_ID_WIDTH-1:0].
- If N==0: go to FINISH with no streaming and no phase activity. Otherwise ref_id=1, phase=0, go to STREAM.
- STREAM: issue reads for addr = ref_id..N, one per cycle, no bubbles. After issuing addr N, go to FLUSH.
- FLUSH: 2 cycles, phase held 0 until the word for id N has shown data_valid=1.
- After FLUSH, phase=1 starting the cycle after that last valid word, and the FSM enters DRAIN for DRAIN_CYCLES cycles.
- DRAIN end: if ref_id==N, go to FINISH with phase left at 0. Otherwise ref_id increments in the same cycle phase returns to 0, and the FSM re-enters STREAM.
- Consequence for receivers: on the prev_phase=1, phase=0 cycle, ref_id is already the new value and no data_valid is present.
- Last pass (ref_id==N): streams only id N.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- prev_phase: plain register of phase; reset 0.
- start while busy: ignored, no effect on the current broadcast.
- Arithmetic: address counter is PARTICLE_ID_WIDTH wide. The comparison against N is on the exact value, so N = 2^PARTICLE_ID_WIDTH-1 terminates without wrap.

Decomposition:
- Shared package: PARTICLE_ID_WIDTH, OFFSET_WIDTH, the 1-based id convention, COUNT_ADDR = 0, FSM state encoding.
- One natural sub-module: bcast_read_pipe, the 2-stage delay line carrying {particle_id, data_valid} alongside RAM data.

Test Plan:
- RAM[0].x=3, ids 1..3 distinct; pulse start -> reading_particle_num 1 cycle with x=3. Pass 1 streams ids 1,2,3; pass 2 streams 2,3; pass 3 streams 3; done pulses once; total valid words = 6.
- Same stimulus, DRAIN_CYCLES=8 -> phase=1 for exactly 8 cycles per pass. Each 1->0 edge has prev_phase=1, phase=0, ref_id already incremented, data_valid=0.
- RAM[0].x=0 -> reading_particle_num pulse, no data_valid, phase stays 0, done 3 cycles after start.
- RAM[0].x=0x7F (127) -> final pass streams only id 127; no address wrap; 8128 valid words total.
- Assert rst mid-STREAM of pass 2 (N=5) -> all outputs 0 immediately without waiting for clk. A new start then replays from the count word.
- Pulse start again during pass 1 -> ignored; the broadcast sequence is identical to the single-start run.
